// File: rtl/depacketizer_1_if.sv
// Handshake bundle between the NoC output port, the depacketizer and its consumer.
// The master side drives flits in and accepts payloads; the slave side is the depacketizer.
interface depacketizer_1_if #(
  parameter int WIDTH_IN    = 36,
  parameter int WIDTH_OUT   = 12,
  parameter int COUNT_WIDTH = 8
);
  logic [WIDTH_IN-1:0]    data_in;
  logic                   valid_in;
  logic                   ready_out;
  logic [WIDTH_OUT-1:0]   data_out;
  logic                   valid_out;
  logic                   ready_in;
  logic [COUNT_WIDTH-1:0] drop_count;
  logic                   drop_pulse;

  modport master (
    output data_in, valid_in, ready_in,
    input  ready_out, data_out, valid_out, drop_count, drop_pulse
  );

  modport slave (
    input  data_in, valid_in, ready_in,
    output ready_out, data_out, valid_out, drop_count, drop_pulse
  );
endinterface

// File: rtl/depacketizer_1.sv
// Single-flit depacketizer: validates the flit header, strips it and queues the payload
// in a 2-entry skid FIFO; malformed or misrouted flits are dropped and counted.
module depacketizer_1 #(
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int WIDTH_IN         = 36,
  parameter int WIDTH_OUT        = 12,
  parameter int MY_ADDRESS       = 0,
  parameter int CHECK_DEST       = 1,
  parameter int COUNT_WIDTH      = 8
) (
  input logic             clk,
  input logic             rst,
  depacketizer_1_if.slave bus
);
  localparam int H  = WIDTH_IN / 2;
  localparam int FD = H - 3 - ADDRESS_WIDTH - VC_ADDRESS_WIDTH;
  localparam int FA = (FD < WIDTH_OUT) ? FD : WIDTH_OUT;

  logic [H-1:0]                w_flit;
  logic [VC_ADDRESS_WIDTH-1:0] w_vc;
  logic [ADDRESS_WIDTH-1:0]    w_dst;
  logic [FD-1:0]               w_field;
  logic [WIDTH_OUT-1:0]        w_payload;
  logic                        w_bad;
  logic                        w_accept;
  logic                        w_push;
  logic                        w_pop;
  logic [1:0]                  w_count_next;
  logic                        w_unused;

  logic [WIDTH_OUT-1:0]   r_mem [2];
  logic                   r_wr_ptr;
  logic                   r_rd_ptr;
  logic [1:0]             r_count;
  logic                   r_ready_out;
  logic                   r_drop_pulse;
  logic [COUNT_WIDTH-1:0] r_drop_count;

  assign w_flit  = bus.data_in[H-1:0];
  assign w_vc    = w_flit[H-4 -: VC_ADDRESS_WIDTH];
  assign w_dst   = w_flit[H-4-VC_ADDRESS_WIDTH -: ADDRESS_WIDTH];
  assign w_field = w_flit[FD-1:0];

  // Upper flit half and the VC id carry nothing this node needs.
  assign w_unused = ^{bus.data_in[WIDTH_IN-1:H], w_vc, w_field};

  // Payload is the top FA field bits, left-aligned in the output word.
  always_comb begin
    w_payload = '0;
    for (int i = 0; i < FA; i++) begin
      w_payload[WIDTH_OUT-1-i] = w_field[FD-1-i];
    end
  end

  assign w_bad = !w_flit[H-1] || !w_flit[H-2] || !w_flit[H-3] ||
                 ((CHECK_DEST != 0) && (w_dst != ADDRESS_WIDTH'(MY_ADDRESS)));

  assign w_accept     = bus.valid_in && r_ready_out;
  assign w_push       = w_accept && !w_bad;
  assign w_pop        = (r_count != 2'd0) && bus.ready_in;
  assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_payload;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= 2'd0;
      r_ready_out <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count     <= w_count_next;
      r_ready_out <= (w_count_next != 2'd2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_pulse <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_drop_pulse <= w_accept && w_bad;
      if (w_accept && w_bad && (r_drop_count != '1)) begin
        r_drop_count <= r_drop_count + 1'b1;
      end
    end
  end

  // Gate with occupancy so a freshly reset or drained FIFO never shows stale data.
  assign bus.valid_out  = (r_count != 2'd0);
  assign bus.data_out   = (r_count != 2'd0) ? r_mem[r_rd_ptr] : '0;
  assign bus.ready_out  = r_ready_out;
  assign bus.drop_pulse = r_drop_pulse;
  assign bus.drop_count = r_drop_count;
endmodule
